// File: rtl/gpio_pad_ctrl.sv
// GPIO pad-ring controller: Wishbone register file driving pad data-out/OEN,
// synchronizing pad inputs and raising a level interrupt on per-pin edges.
module gpio_pad_ctrl #(
   parameter int unsigned NUM_GPIO    = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                i_wb_cyc,
   input  logic                i_wb_stb,
   input  logic                i_wb_we,
   input  logic [2:0]          i_wb_adr,
   input  logic [31:0]         i_wb_dat,
   input  logic [3:0]          i_wb_sel,
   output logic [31:0]         o_wb_dat,
   output logic                o_wb_ack,
   input  logic [NUM_GPIO-1:0] i_pad_c,
   output logic [NUM_GPIO-1:0] o_pad_i,
   output logic [NUM_GPIO-1:0] o_pad_oen,
   output logic                o_irq
);

   localparam int unsigned WB_W   = 32;
   localparam int unsigned SYNC_W = SYNC_STAGES * NUM_GPIO;

   localparam logic [2:0] ADR_DATA_OUT = 3'd0;
   localparam logic [2:0] ADR_OEN      = 3'd1;
   localparam logic [2:0] ADR_DATA_IN  = 3'd2;
   localparam logic [2:0] ADR_IRQ_EN   = 3'd3;
   localparam logic [2:0] ADR_IRQ_EDGE = 3'd4;
   localparam logic [2:0] ADR_IRQ_PEND = 3'd5;
   localparam logic [2:0] ADR_OUT_SET  = 3'd6;
   localparam logic [2:0] ADR_OUT_CLR  = 3'd7;

   logic [NUM_GPIO-1:0] r_data_out;
   logic [NUM_GPIO-1:0] r_oen;
   logic [NUM_GPIO-1:0] r_irq_en;
   logic [NUM_GPIO-1:0] r_irq_edge;
   logic [NUM_GPIO-1:0] r_irq_pend;
   logic [NUM_GPIO-1:0] r_prev;
   logic [SYNC_W-1:0]   r_sync;
   logic                r_ack;
   logic                r_irq;
   logic [WB_W-1:0]     r_rdat;

   logic                w_req;
   logic                w_wr;
   logic [WB_W-1:0]     w_bmask_full;
   logic [NUM_GPIO-1:0] w_bmask;
   logic [NUM_GPIO-1:0] w_wdat;
   logic [NUM_GPIO-1:0] w_wbits;
   logic [NUM_GPIO-1:0] w_sync_out;
   logic [NUM_GPIO-1:0] w_rise;
   logic [NUM_GPIO-1:0] w_fall;
   logic [NUM_GPIO-1:0] w_hit;
   logic [NUM_GPIO-1:0] w_data_out_nxt;
   logic [NUM_GPIO-1:0] w_oen_nxt;
   logic [NUM_GPIO-1:0] w_irq_en_nxt;
   logic [NUM_GPIO-1:0] w_irq_edge_nxt;
   logic [NUM_GPIO-1:0] w_irq_pend_nxt;
   logic [WB_W-1:0]     w_rdat_nxt;

   // A request is never accepted in the cycle its predecessor is acked.
   assign w_req        = i_wb_cyc & i_wb_stb & ~r_ack;
   assign w_wr         = w_req & i_wb_we;
   assign w_bmask_full = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
   assign w_bmask      = w_bmask_full[NUM_GPIO-1:0];
   assign w_wdat       = i_wb_dat[NUM_GPIO-1:0];
   assign w_wbits      = w_wdat & w_bmask;

   assign w_sync_out = r_sync[SYNC_W-1 -: NUM_GPIO];
   assign w_rise     = w_sync_out & ~r_prev;
   assign w_fall     = ~w_sync_out & r_prev;
   assign w_hit      = r_irq_en & ((r_irq_edge & w_rise) | (~r_irq_edge & w_fall));

   function automatic logic [NUM_GPIO-1:0] merge(input logic [NUM_GPIO-1:0] old_v,
                                                input logic [NUM_GPIO-1:0] new_v,
                                                input logic [NUM_GPIO-1:0] mask);
      return (old_v & ~mask) | (new_v & mask);
   endfunction

   // Register next-state and read mux; a new edge always wins over W1C.
   always_comb begin
      w_data_out_nxt = r_data_out;
      w_oen_nxt      = r_oen;
      w_irq_en_nxt   = r_irq_en;
      w_irq_edge_nxt = r_irq_edge;
      w_irq_pend_nxt = r_irq_pend | w_hit;
      w_rdat_nxt     = r_rdat;
      if (w_wr) begin
         case (i_wb_adr)
            ADR_DATA_OUT: w_data_out_nxt = merge(r_data_out, w_wdat, w_bmask);
            ADR_OEN:      w_oen_nxt      = merge(r_oen, w_wdat, w_bmask);
            ADR_IRQ_EN:   w_irq_en_nxt   = merge(r_irq_en, w_wdat, w_bmask);
            ADR_IRQ_EDGE: w_irq_edge_nxt = merge(r_irq_edge, w_wdat, w_bmask);
            ADR_IRQ_PEND: w_irq_pend_nxt = (r_irq_pend & ~w_wbits) | w_hit;
            ADR_OUT_SET:  w_data_out_nxt = r_data_out | w_wbits;
            ADR_OUT_CLR:  w_data_out_nxt = r_data_out & ~w_wbits;
            default:      ;
         endcase
      end
      if (w_req) begin
         w_rdat_nxt = '0;
         if (!i_wb_we) begin
            case (i_wb_adr)
               ADR_DATA_OUT: w_rdat_nxt = WB_W'(r_data_out);
               ADR_OEN:      w_rdat_nxt = WB_W'(r_oen);
               ADR_DATA_IN:  w_rdat_nxt = WB_W'(w_sync_out);
               ADR_IRQ_EN:   w_rdat_nxt = WB_W'(r_irq_en);
               ADR_IRQ_EDGE: w_rdat_nxt = WB_W'(r_irq_edge);
               ADR_IRQ_PEND: w_rdat_nxt = WB_W'(r_irq_pend);
               default:      w_rdat_nxt = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data_out <= '0;
         r_oen      <= '1;
         r_irq_en   <= '0;
         r_irq_edge <= '0;
         r_irq_pend <= '0;
         r_ack      <= 1'b0;
         r_rdat     <= '0;
         r_irq      <= 1'b0;
      end else begin
         r_data_out <= w_data_out_nxt;
         r_oen      <= w_oen_nxt;
         r_irq_en   <= w_irq_en_nxt;
         r_irq_edge <= w_irq_edge_nxt;
         r_irq_pend <= w_irq_pend_nxt;
         r_ack      <= w_req;
         r_rdat     <= w_rdat_nxt;
         r_irq      <= |(r_irq_pend & r_irq_en);
      end
   end

   // Input synchronizer chain plus the previous-value flop for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= '0;
         r_prev <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_W-NUM_GPIO-1:0], i_pad_c};
         r_prev <= w_sync_out;
      end
   end

   assign o_wb_dat  = r_rdat;
   assign o_wb_ack  = r_ack;
   assign o_pad_i   = r_data_out;
   assign o_pad_oen = r_oen;
   assign o_irq     = r_irq;

endmodule

// File: doc/gpio_pad_ctrl.md
# gpio_pad_ctrl

Register-mapped controller for the 32 bidirectional GPIO pads in the SoC pad ring. It sits between the core's Wishbone data bus and the GPIO pad cells. It drives each pad's data-out and active-low output enable (OEN). It synchronizes each pad's input (C) into the clock domain and raises a level interrupt on enabled, per-pin-configurable edges. It replaces direct core wiring of the i_gpio/o_gpio/en_gpio nets.

## Interface
Parameters:
- NUM_GPIO, 32: number of pads controlled; 1..32. Register bits above NUM_GPIO-1 read 0 and ignore writes.
- SYNC_STAGES, 2: input synchronizer depth; ≥2.

Ports:
- clk  in  1  system clock. One clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- i_wb_cyc  in  1  Wishbone cycle.
- i_wb_stb  in  1  Wishbone strobe.
- i_wb_we  in  1  1 = write.
- i_wb_adr  in  3  word address (byte offset bits [4:2]).
- i_wb_dat  in  32  write data.
- i_wb_sel  in  4  byte enables.
- o_wb_dat  out  32  read data, valid while o_wb_ack=1.
- o_wb_ack  out  1  single-cycle acknowledge.
- i_pad_c  in  NUM_GPIO  pad input (C) nets; asynchronous.
- o_pad_i  out  NUM_GPIO  pad data-out (I) nets.
- o_pad_oen  out  NUM_GPIO  pad OEN nets. 0 = drive pad, 1 = input.
- o_irq  out  1  level interrupt to core, registered.

## Operation
Register map (offset, access):
- 0x00 DATA_OUT, RW. Drives o_pad_i.
- 0x04 OEN, RW. Drives o_pad_oen.
- 0x08 DATA_IN, RO. Synchronized pad inputs.
- 0x0C IRQ_EN, RW.
- 0x10 IRQ_EDGE, RW. 1 = rising, 0 = falling.
- 0x14 IRQ_PEND, R/W1C.
- 0x18 OUT_SET, WO. DATA_OUT |= wdata. Reads return 0.
- 0x1C OUT_CLR, WO. DATA_OUT &= ~wdata. Reads return 0.

Write behaviour:
- i_wb_sel is honored per byte for every write, including W1C, SET and CLR.
- Unselected bytes are unchanged.

Input path:
- Each pin passes through a SYNC_STAGES flop chain, then one extra "previous" flop.
- A rise is sync_out=1 and prev=0. A fall is sync_out=0 and prev=1.

Pending and interrupt:
- IRQ_PEND[k] sets on the configured edge only if IRQ_EN[k]=1 in that cycle.
- Once set, IRQ_PEND[k] holds until cleared by W1C.
- Clearing IRQ_EN does not clear pending.
- o_irq is the registered value of |(IRQ_PEND & IRQ_EN).

Reset values (asynchronous on reset_n=0):
- DATA_OUT=0.
- OEN=all 1, so every pad is an input after reset.
- IRQ_EN=0, IRQ_EDGE=0, IRQ_PEND=0.
- Synchronizer and prev flops 0.
- o_wb_ack=0, o_wb_dat=0, o_irq=0.

## Timing
Bus handshake:
- A request is i_wb_cyc & i_wb_stb & !o_wb_ack, sampled at a clock edge.
- o_wb_ack goes high for exactly one cycle after the request.
- The cycle after ack is always ack=0. Requests are therefore serviced at most every other cycle.
- Write side effects commit at the same edge that raises o_wb_ack.
- o_wb_dat is registered at that edge and held until the next ack. It returns 0 for write cycles.
- Unmapped offsets do not exist with a 3-bit address. Bits ≥NUM_GPIO read 0.
- Dropping i_wb_cyc while ack is pending does not cancel the write. The ack still pulses once.

Output path:
- o_pad_i and o_pad_oen change at the write's ack edge. There is no added latency.

Input latency:
- A pad change is visible in DATA_IN SYNC_STAGES edges later.
- IRQ_PEND sets at edge SYNC_STAGES+1.
- o_irq asserts at edge SYNC_STAGES+2.

Simultaneous events:
- W1C and a new qualifying edge on the same bit in the same cycle: the bit stays 1. The set wins.
- A write to IRQ_EDGE or IRQ_EN takes effect for detection from the next cycle. It never retroactively sets pending.
- A glitch shorter than one clock may be missed. This is acceptable.

Reset mid-transaction:
- The ack is dropped and the write is lost.
- After release, the first request is accepted normally.

Pins held high at reset release:
- These produce a rise on the prev flop.
- Nothing latches, because IRQ_EN=0.

## Test plan
- Reset: assert reset_n=0 mid-write to DATA_OUT. Expect o_pad_oen=0xFFFFFFFF, o_pad_i=0, o_irq=0, ack=0. After release, read OEN → 0xFFFFFFFF with a one-cycle ack.
- Output control:
  - Write OEN=0x0000FFFF and DATA_OUT=0x00000A5A. Expect o_pad_i=0x00000A5A and o_pad_oen=0x0000FFFF at the ack edge.
  - OUT_SET 0x0001 then OUT_CLR 0x0008. Expect DATA_OUT=0x00000A53.
  - Write with i_wb_sel=0001 to DATA_OUT with 0xFFFFFFFF. Expect 0x00000AFF.
- Input sync: toggle i_pad_c[5] 0→1. Expect DATA_IN bit5=1 on a read started ≥2 cycles later and not earlier. The IRQ_PEND read stays 0 because IRQ_EN=0.
- Rising IRQ: set IRQ_EN=0x20 and IRQ_EDGE=0x20, then raise pin 5. Expect IRQ_PEND=0x20 at edge 3 and o_irq=1 at edge 4. Write 0x20 to IRQ_PEND → o_irq=0 one cycle after the ack.
- Falling IRQ and collision: set IRQ_EDGE bit3=0 and IRQ_EN bit3=1. Drop pin 3 so its fall arrives in the same cycle as a W1C of 0x08. Expect IRQ_PEND=0x08 and o_irq to stay 1.
- Back-to-back: hold cyc/stb high for 6 cycles with reads of 0x08. Expect the ack pattern 0,1,0,1,0,1 and exactly 3 responses.
